// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Request scheduler and motion sequencer for a single elevator car.
//   Latches floor calls, picks a travel direction with a SCAN policy,
//   tracks the current floor from arrival pulses and times the door dwell.
//
// Ports
//   clk           in  1        single rising-edge clock
//   reset         in  1        synchronous, active-high; dominates all inputs
//   req           in  FLOORS   call buttons, one bit per floor
//   floor_sensor  in  1        one-cycle pulse: car reached next floor
//   motion_cmd    out 2        00 stop, 01 up, 10 down (11 never driven)
//   door_open     out 1        high while dwelling at a floor
//   cur_floor     out FW       current or last-passed floor
//   pending       out FLOORS   latched, unserviced requests
module elevator_scheduler #(
    parameter int FLOORS      = 4,
    parameter int DOOR_CYCLES = 4,
    parameter int FW          = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] req,
    input  logic              floor_sensor,
    output logic [1:0]        motion_cmd,
    output logic              door_open,
    output logic [FW-1:0]     cur_floor,
    output logic [FLOORS-1:0] pending
);

    localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR  = FW'(FLOORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_DOOR
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_dir_up, w_dir_up_nxt;
    logic [FW-1:0]     r_cur, w_cur_nxt;
    logic [FLOORS-1:0] r_pending, w_pending_nxt;
    logic [TW-1:0]     r_timer, w_timer_nxt;
    logic [FLOORS-1:0] w_req_lat;
    logic [FLOORS-1:0] w_clear;
    logic [FW-1:0]     w_step_floor;
    logic              w_at_limit;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++)
            if (i > 32'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++)
            if (i < 32'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic ahead(input logic [FLOORS-1:0] p, input logic [FW-1:0] f,
                                   input logic up);
        return up ? any_above(p, f) : any_below(p, f);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dir_up  <= 1'b1;
            r_cur     <= '0;
            r_pending <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir_up  <= w_dir_up_nxt;
            r_cur     <= w_cur_nxt;
            r_pending <= w_pending_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_up_nxt = r_dir_up;
        w_cur_nxt    = r_cur;
        w_timer_nxt  = r_timer;
        w_clear      = '0;
        w_req_lat    = req;
        w_step_floor = (r_state == ST_UP) ? r_cur + FW'(1) : r_cur - FW'(1);
        w_at_limit   = (r_state == ST_UP) ? (r_cur == TOP_FLOOR) : (r_cur == '0);

        case (r_state)
            ST_IDLE: begin
                if (r_pending[r_cur]) begin
                    w_state_nxt    = ST_DOOR;
                    w_clear[r_cur] = 1'b1;
                    w_timer_nxt    = TIMER_LOAD;
                end else if (ahead(r_pending, r_cur, r_dir_up)) begin
                    w_state_nxt = r_dir_up ? ST_UP : ST_DOWN;
                end else if (ahead(r_pending, r_cur, ~r_dir_up)) begin
                    w_dir_up_nxt = ~r_dir_up;
                    w_state_nxt  = r_dir_up ? ST_DOWN : ST_UP;
                end
            end
            ST_UP, ST_DOWN: begin
                if (floor_sensor && !w_at_limit) begin
                    w_cur_nxt = w_step_floor;
                    if (r_pending[w_step_floor]) begin
                        w_state_nxt           = ST_DOOR;
                        w_clear[w_step_floor] = 1'b1;
                        w_timer_nxt           = TIMER_LOAD;
                    end else if (!ahead(r_pending, w_step_floor, r_state == ST_UP)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                // A call at the open floor holds the door instead of queueing a stop.
                w_req_lat[r_cur] = 1'b0;
                if (req[r_cur]) begin
                    w_timer_nxt = TIMER_LOAD;
                end else if (r_timer == '0) begin
                    if (ahead(r_pending, r_cur, r_dir_up)) begin
                        w_state_nxt = r_dir_up ? ST_UP : ST_DOWN;
                    end else if (ahead(r_pending, r_cur, ~r_dir_up)) begin
                        w_dir_up_nxt = ~r_dir_up;
                        w_state_nxt  = r_dir_up ? ST_DOWN : ST_UP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_pending_nxt = (r_pending | w_req_lat) & ~w_clear;
    end

    always_comb begin
        motion_cmd = 2'b00;
        door_open  = 1'b0;
        case (r_state)
            ST_UP:   motion_cmd = 2'b01;
            ST_DOWN: motion_cmd = 2'b10;
            ST_DOOR: door_open  = 1'b1;
            default: ;
        endcase
    end

    assign cur_floor = r_cur;
    assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

    localparam int FLOORS = 4;
    localparam int DOORC  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic       floor_sensor = 1'b0;
    logic [1:0] motion_cmd;
    logic       door_open;
    logic [1:0] cur_floor;
    logic [3:0] pending;

    elevator_scheduler #(.FLOORS(FLOORS), .DOOR_CYCLES(DOORC)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .floor_sensor (floor_sensor),
        .motion_cmd   (motion_cmd),
        .door_open    (door_open),
        .cur_floor    (cur_floor),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] mc;
        logic       dopen;
        logic [1:0] cf;
        logic [3:0] pend;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cycle = cycle + 1;

    // Monitor: compares the DUT outputs after each edge against the expected record for that edge.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cycle) begin
            exp_t e;
            e = q.pop_front();
            n_cmp = n_cmp + 1;
            if ({motion_cmd, door_open, cur_floor, pending} !== {e.mc, e.dopen, e.cf, e.pend}) begin
                n_bad = n_bad + 1;
                $display("FAIL %s (cycle %0d): got mc=%b door=%b floor=%0d pend=%b, want mc=%b door=%b floor=%0d pend=%b",
                         e.name, cycle, motion_cmd, door_open, cur_floor, pending,
                         e.mc, e.dopen, e.cf, e.pend);
            end
        end
    end

    // Drive one edge's inputs and queue the outputs expected after that edge.
    task automatic step(input logic rst, input logic [3:0] rq, input logic fs,
                        input logic [1:0] mc, input logic d, input logic [1:0] cf,
                        input logic [3:0] pd, input string nm);
        exp_t e;
        reset        = rst;
        req          = rq;
        floor_sensor = fs;
        e.cyc   = cycle + 1;
        e.mc    = mc;
        e.dopen = d;
        e.cf    = cf;
        e.pend  = pd;
        e.name  = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random calls present
        step(1, 4'($urandom_range(0, 15)), 0, 2'b00, 0, 0, 4'b0000, "reset_1");
        step(1, 4'($urandom_range(0, 15)), 0, 2'b00, 0, 0, 4'b0000, "reset_2");

        // Call at current floor 0
        step(0, 4'b0001, 0, 2'b00, 0, 0, 4'b0001, "here_latch");
        step(0, 4'b0000, 0, 2'b00, 1, 0, 4'b0000, "here_door1");
        step(0, 4'b0000, 0, 2'b00, 1, 0, 4'b0000, "here_door2");
        step(0, 4'b0000, 0, 2'b00, 1, 0, 4'b0000, "here_door3");
        step(0, 4'b0000, 0, 2'b00, 0, 0, 4'b0000, "here_idle");

        // Single trip up 0 -> 2
        step(0, 4'b0100, 0, 2'b00, 0, 0, 4'b0100, "up_latch");
        step(0, 4'b0000, 0, 2'b01, 0, 0, 4'b0100, "up_start");
        step(0, 4'b0000, 0, 2'b01, 0, 0, 4'b0100, "up_hold");
        step(0, 4'b0000, 1, 2'b01, 0, 1, 4'b0100, "up_pass1");
        step(0, 4'b0000, 1, 2'b00, 1, 2, 4'b0000, "up_arrive2");
        step(0, 4'b0000, 0, 2'b00, 1, 2, 4'b0000, "up_door2");
        step(0, 4'b0000, 0, 2'b00, 1, 2, 4'b0000, "up_door3");
        step(0, 4'b0000, 0, 2'b00, 0, 2, 4'b0000, "up_idle");

        // Door reload at floor 2: call sampled on the first edge inside DOOR
        step(0, 4'b0100, 0, 2'b00, 0, 2, 4'b0100, "rl_latch");
        step(0, 4'b0000, 0, 2'b00, 1, 2, 4'b0000, "rl_door1");
        step(0, 4'b0100, 0, 2'b00, 1, 2, 4'b0000, "rl_reload");
        step(0, 4'b0000, 0, 2'b00, 1, 2, 4'b0000, "rl_door3");
        step(0, 4'b0000, 0, 2'b00, 1, 2, 4'b0000, "rl_door4");
        step(0, 4'b0000, 0, 2'b00, 0, 2, 4'b0000, "rl_idle");

        // Reset mid-move: call behind reverses to DOWN, then reset with calls asserted
        step(0, 4'b0001, 0, 2'b00, 0, 2, 4'b0001, "rm_latch");
        step(0, 4'b0000, 0, 2'b10, 0, 2, 4'b0001, "rm_down");
        step(1, 4'b1111, 0, 2'b00, 0, 0, 4'b0000, "rm_reset");
        step(0, 4'b0000, 1, 2'b00, 0, 0, 4'b0000, "rm_sensor_ign");
        step(0, 4'b0000, 0, 2'b00, 0, 0, 4'b0000, "rm_still_idle");

        // Move to floor 1 (dir stays UP)
        step(0, 4'b0010, 0, 2'b00, 0, 0, 4'b0010, "f1_latch");
        step(0, 4'b0000, 0, 2'b01, 0, 0, 4'b0010, "f1_up");
        step(0, 4'b0000, 1, 2'b00, 1, 1, 4'b0000, "f1_arrive");
        step(0, 4'b0000, 0, 2'b00, 1, 1, 4'b0000, "f1_door2");
        step(0, 4'b0000, 0, 2'b00, 1, 1, 4'b0000, "f1_door3");
        step(0, 4'b0000, 0, 2'b00, 0, 1, 4'b0000, "f1_idle");

        // SCAN from floor 1, dir UP, calls at 0 and 3
        step(0, 4'b1001, 0, 2'b00, 0, 1, 4'b1001, "scan_latch");
        step(0, 4'b0000, 0, 2'b01, 0, 1, 4'b1001, "scan_up");
        step(0, 4'b0000, 1, 2'b01, 0, 2, 4'b1001, "scan_pass2");
        step(0, 4'b0000, 1, 2'b00, 1, 3, 4'b0001, "scan_stop3");
        step(0, 4'b0000, 1, 2'b00, 1, 3, 4'b0001, "scan_door_sensor_ign");
        step(0, 4'b0000, 0, 2'b00, 1, 3, 4'b0001, "scan_door3");
        step(0, 4'b0000, 0, 2'b10, 0, 3, 4'b0001, "scan_reverse");
        step(0, 4'b0000, 1, 2'b10, 0, 2, 4'b0001, "scan_pass2d");
        step(0, 4'b0000, 1, 2'b10, 0, 1, 4'b0001, "scan_pass1d");
        step(0, 4'b0000, 1, 2'b00, 1, 0, 4'b0000, "scan_stop0");
        step(0, 4'b0000, 0, 2'b00, 1, 0, 4'b0000, "scan_door2b");
        step(0, 4'b0000, 0, 2'b00, 1, 0, 4'b0000, "scan_door3b");
        step(0, 4'b0000, 0, 2'b00, 0, 0, 4'b0000, "scan_idle");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expected records never compared, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
